// File: rtl/tick_cascade.sv
// Cascade of clock-enable tick generators: stage 0 divides the clock, each later
// stage divides the registered ticks of the stage before it. Divisors are shadowed.
module tick_cascade #(
  parameter int N_STAGES   = 2,
  parameter int CNT_W      = 16,
  parameter int DIV_INIT_0 = 100,
  parameter int DIV_INIT_N = 5,
  parameter int SEL_W      = 3
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [N_STAGES-1:0] tick
);

  localparam logic [CNT_W-1:0] INIT_0 = CNT_W'(DIV_INIT_0);
  localparam logic [CNT_W-1:0] INIT_N = CNT_W'(DIV_INIT_N);

  logic [CNT_W-1:0]    cnt      [N_STAGES];
  logic [CNT_W-1:0]    div_act  [N_STAGES];
  logic [CNT_W-1:0]    div_sh   [N_STAGES];

  logic [CNT_W-1:0]    cnt_nxt  [N_STAGES];
  logic [CNT_W-1:0]    act_nxt  [N_STAGES];
  logic [CNT_W-1:0]    sh_nxt   [N_STAGES];
  logic [CNT_W-1:0]    last_cnt [N_STAGES];
  logic [N_STAGES-1:0] src;
  logic [N_STAGES-1:0] ev;
  logic [N_STAGES-1:0] hit;
  logic [N_STAGES-1:0] wrap;
  logic [N_STAGES-1:0] tick_nxt;

  // Stage k is driven by the registered tick of stage k-1, so each stage lags one cycle.
  always_comb begin
    src    = '0;
    src[0] = 1'b1;
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      src[k] = tick[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      ev[k]       = en & src[k];
      hit[k]      = cfg_we && (cfg_sel == SEL_W'(k));
      // Divisors 0 and 1 both mean "wrap on every event".
      last_cnt[k] = (div_act[k] == '0) ? '0 : div_act[k] - CNT_W'(1);
      wrap[k]     = ev[k] && (cnt[k] == last_cnt[k]);
      // A write in the same cycle as a reload is forwarded into the reload.
      sh_nxt[k]   = hit[k] ? cfg_div : div_sh[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      cnt_nxt[k]  = cnt[k];
      act_nxt[k]  = div_act[k];
      tick_nxt[k] = 1'b0;
      if (clr) begin
        cnt_nxt[k] = '0;
        act_nxt[k] = sh_nxt[k];
      end else if (wrap[k]) begin
        cnt_nxt[k]  = '0;
        act_nxt[k]  = sh_nxt[k];
        tick_nxt[k] = 1'b1;
      end else if (ev[k]) begin
        cnt_nxt[k] = cnt[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        cnt[k]     <= '0;
        div_act[k] <= (k == 0) ? INIT_0 : INIT_N;
        div_sh[k]  <= (k == 0) ? INIT_0 : INIT_N;
      end
      tick <= '0;
    end else begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        cnt[k]     <= cnt_nxt[k];
        div_act[k] <= act_nxt[k];
        div_sh[k]  <= sh_nxt[k];
      end
      tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_tick_cascade.sv
// Directed and randomized bench for tick_cascade, checked against a countdown
// reference model and closed-form tick schedules.
module tb_tick_cascade;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n, en, clr, cfg_we;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_div;
  logic [1:0]  tick;

  logic        rst_b, en_b, clr_b, cfg_we_b;
  logic [2:0]  cfg_sel_b;
  logic [3:0]  cfg_div_b;
  logic [2:0]  tick_b;

  tick_cascade #(.N_STAGES(2), .CNT_W(16), .DIV_INIT_0(100), .DIV_INIT_N(5), .SEL_W(3)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .clr(clr), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .tick(tick)
  );

  tick_cascade #(.N_STAGES(3), .CNT_W(4), .DIV_INIT_0(15), .DIV_INIT_N(15), .SEL_W(3)) dut_b (
    .clk_in(clk_in), .rst_n(rst_b), .en(en_b), .clr(clr_b), .cfg_we(cfg_we_b),
    .cfg_sel(cfg_sel_b), .cfg_div(cfg_div_b), .tick(tick_b)
  );

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: events remaining until each stage's next tick.
  int         sh [2];
  int         rem[2];
  logic [1:0] mtick;

  int n_edge, last_t0, gap0, cnt_t0, cnt_t1, first_t0, first_t1;
  bit seen0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int eff(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  task automatic model_reset();
    sh[0] = 100; sh[1] = 5;
    rem[0] = 100; rem[1] = 5;
    mtick = '0;
  endtask

  task automatic model_edge();
    logic [1:0] nt;
    int s;
    bit evk;
    nt = '0;
    s = int'(cfg_sel);
    if (cfg_we && s < 2) sh[s] = int'(cfg_div);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        rem[k] = eff(sh[k]);
      end else begin
        evk = en && (k == 0 || mtick[0]);
        if (evk) begin
          rem[k] = rem[k] - 1;
          if (rem[k] == 0) begin
            nt[k] = 1'b1;
            rem[k] = eff(sh[k]);
          end
        end
      end
    end
    mtick = nt;
  endtask

  task automatic restart_counters();
    n_edge = 0; last_t0 = 0; gap0 = 0; cnt_t0 = 0; cnt_t1 = 0; first_t0 = 0; first_t1 = 0;
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    n_edge++;
    check("tick", 32'(tick), 32'(mtick));
    seen0 = (tick[0] === 1'b1);
    if (tick[0] === 1'b1) begin
      gap0 = n_edge - last_t0;
      last_t0 = n_edge;
      cnt_t0++;
      if (first_t0 == 0) first_t0 = n_edge;
    end
    if (tick[1] === 1'b1) begin
      cnt_t1++;
      if (first_t1 == 0) first_t1 = n_edge;
    end
  endtask

  task automatic wait_t0(input string tag, input int budget);
    int i;
    i = 0;
    seen0 = 0;
    while (!seen0 && i < budget) begin
      step();
      i++;
    end
    check(tag, 32'(seen0), 32'd1);
  endtask

  task automatic run_defaults(input string pfx);
    restart_counters();
    en = 1'b1;
    repeat (1001) step();
    check({pfx, "_first_t0"}, first_t0, 100);
    check({pfx, "_first_t1"}, first_t1, 501);
    check({pfx, "_count_t0"}, cnt_t0, 10);
    check({pfx, "_count_t1"}, cnt_t1, 2);
    check({pfx, "_period_t0"}, gap0, 100);
  endtask

  initial begin
    int first_t2, gap_t2, last_t2;
    logic [2:0] eb;
    rst_n = 1'b0; rst_b = 1'b0; en = 1'b0; clr = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;
    en_b = 1'b0; clr_b = 1'b0; cfg_we_b = 1'b0; cfg_sel_b = '0; cfg_div_b = '0;
    model_reset();
    #12;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_tick_b", 32'(tick_b), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;

    run_defaults("dflt");

    // Mid-period write at cnt0 = 40, then a write coincident with a wrap.
    while (n_edge - last_t0 < 40) step();
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd10; step(); cfg_we = 1'b0;
    wait_t0("wr_mid_timeout", 200);
    check("wr_mid_gap", gap0, 100);
    wait_t0("wr_new_timeout", 50);
    check("wr_new_gap", gap0, 10);
    repeat (9) step();
    cfg_we = 1'b1; cfg_div = 16'd30; step(); cfg_we = 1'b0;
    check("wr_wrap_gap", gap0, 10);
    wait_t0("wr_wrap_timeout", 100);
    check("wr_bypass_gap", gap0, 30);

    // Stage 1 with divisor 0, then 1: tick[1] trails every tick[0] by one cycle.
    for (int d = 0; d < 2; d++) begin
      cfg_we = 1'b1; cfg_sel = 3'd1; cfg_div = 16'(d); step(); cfg_we = 1'b0;
      clr = 1'b1; step(); clr = 1'b0;
      check("clr_tick_zero", 32'(tick), 32'd0);
      last_t0 = n_edge;
      wait_t0("div01_timeout", 100);
      check("div01_gap", gap0, 30);
      step();
      check("div01_follow", 32'(tick), 32'd2);
    end

    // Out-of-range stage index is ignored.
    cfg_we = 1'b1; cfg_sel = 3'd7; cfg_div = 16'd3; step(); cfg_we = 1'b0;
    repeat (2) begin
      wait_t0("sel7_timeout", 100);
      check("sel7_gap", gap0, 30);
      step();
      check("sel7_follow", 32'(tick), 32'd2);
    end

    // tick[0] high while en is low must not advance stage 1.
    wait_t0("gate_timeout", 100);
    en = 1'b0; step(); en = 1'b1;
    check("en_gate_t1", 32'(tick[1]), 32'd0);

    // Back to 100/5 through a clear.
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd100; step();
    cfg_sel = 3'd1; cfg_div = 16'd5; step(); cfg_we = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    last_t0 = n_edge;
    wait_t0("restore_timeout", 200);
    check("restore_gap", gap0, 100);

    // en low for 37 cycles stretches the period by 37.
    repeat (50) step();
    en = 1'b0; repeat (37) step(); en = 1'b1;
    wait_t0("stall_timeout", 300);
    check("stall_gap", gap0, 137);

    // clr at cnt0 = 63 with a pending shadow of 20.
    while (n_edge - last_t0 < 10) step();
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd20; step(); cfg_we = 1'b0;
    while (n_edge - last_t0 < 63) step();
    clr = 1'b1; step(); clr = 1'b0;
    check("clr63_tick", 32'(tick), 32'd0);
    last_t0 = n_edge;
    wait_t0("clr63_timeout", 100);
    check("clr63_gap", gap0, 20);

    // Coincident clr + write of 7.
    repeat (5) step();
    clr = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd7; step();
    clr = 1'b0; cfg_we = 1'b0;
    last_t0 = n_edge;
    wait_t0("clrwr_timeout", 50);
    check("clrwr_gap", gap0, 7);
    // clr on what would be a wrap edge suppresses the tick.
    repeat (6) step();
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_on_wrap", 32'(tick), 32'd0);
    last_t0 = n_edge;
    wait_t0("clrwrap_timeout", 50);
    check("clrwrap_gap", gap0, 7);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      en      = ($urandom_range(7) != 0);
      clr     = ($urandom_range(127) == 0);
      cfg_we  = ($urandom_range(31) == 0);
      cfg_sel = 3'($urandom_range(7));
      cfg_div = 16'($urandom_range((cfg_sel == 3'd0) ? 20 : 6));
      step();
    end
    en = 1'b1; clr = 1'b0; cfg_we = 1'b0;

    // Asynchronous reset while tick[0] is high, between edges.
    wait_t0("prerst_timeout", 200);
    #2 rst_n = 1'b0;
    #1 check("async_rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    run_defaults("rerun");

    // 3-stage, 4-bit counters at 15/15/15: closed-form tick schedule.
    en = 1'b0;
    en_b = 1'b1;
    first_t2 = 0; gap_t2 = 0; last_t2 = 0;
    @(negedge clk_in);
    rst_b = 1'b1;
    for (int i = 1; i <= 6760; i++) begin
      @(posedge clk_in);
      #1;
      eb[0] = (i % 15 == 0);
      eb[1] = (i > 1) && ((i - 1) % 225 == 0);
      eb[2] = (i > 2) && ((i - 2) % 3375 == 0);
      check("cascade3_tick", 32'(tick_b), 32'(eb));
      if (tick_b[2] === 1'b1) begin
        if (first_t2 == 0) first_t2 = i;
        gap_t2 = i - last_t2;
        last_t2 = i;
      end
    end
    check("cascade3_first_t2", first_t2, 3377);
    check("cascade3_period_t2", gap_t2, 3375);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
